// File: rtl/c432_key_load_ctrl_pkg.sv
// c432_key_pkg: shared definitions for the c432 key-load controller.
//   - state_e    : sequencer states (IDLE, LOAD, CHECK, COMMIT, FAIL)
//   - KEY_W      : key width (32 key pins keyIn_0_0..keyIn_0_31)
//   - BEAT_W     : key-store beat width
//   - N_BEATS    : key beats per key
//   - CRC8_POLY  : CRC-8 polynomial used when KEY_CRC_CHECK_EN is defined
//   - crc8_next  : one-byte CRC-8 update (MSB-first, no reflection)
package c432_key_pkg;

  localparam int         KEY_W     = 32;
  localparam int         BEAT_W    = 8;
  localparam int         N_BEATS   = KEY_W / BEAT_W;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    FAIL   = 3'd4
  } state_e;

  // Advance a CRC-8 by one byte, most significant bit first.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/c432_key_load_ctrl_crc8.sv
// key_crc8: byte-serial CRC-8 (init 0x00) over accepted key beats.
// Only instantiated when KEY_CRC_CHECK_EN is defined.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   clr_i  : synchronous clear back to the init value
//   en_i   : fold data_i into the running CRC this cycle
//   data_i : byte to fold in
//   crc_o  : current CRC value (registered)
module key_crc8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);
  import c432_key_pkg::*;

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Next CRC value: clear wins over update.
  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (en_i) begin
      crc_d = crc8_next(crc_q, data_i);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/c432_key_load_ctrl.sv
// c432_key_load_ctrl: loads the 32-bit unlock key of the locked c432 core.
// Byte beats arrive LSB-first over valid/ready, are assembled in a shadow
// register and committed to the key pins in one step. The 7 core outputs
// are forced to 0 until a committed key is valid.
// Optional feature macro: KEY_CRC_CHECK_EN (adds a trailing CRC-8 beat that
// must match the key beats, otherwise the load fails).
// Ports:
//   clk, rst (async, active-high)
//   load_req            : one-cycle pulse starting a load (ignored while busy)
//   kin_valid/kin_ready : beat handshake, kin_data is the beat
//   key_out             : drives keyIn_0_[KEY_W-1:0]
//   key_valid           : committed key present
//   busy                : load in progress
//   err                 : sticky failure of the last load
//   core_out_in/core_out: raw and gated core outputs
module c432_key_load_ctrl #(
  parameter int KEY_W   = c432_key_pkg::KEY_W,
  parameter int BEAT_W  = c432_key_pkg::BEAT_W,
  parameter int N_OUT   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              kin_valid,
  output logic              kin_ready,
  input  logic [BEAT_W-1:0] kin_data,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              busy,
  output logic              err,
  input  logic [N_OUT-1:0]  core_out_in,
  output logic [N_OUT-1:0]  core_out
);
  import c432_key_pkg::*;

  localparam int N_KEY_BEATS = KEY_W / BEAT_W;
`ifdef KEY_CRC_CHECK_EN
  localparam int N_LOAD_BEATS = N_KEY_BEATS + 1;
`else
  localparam int N_LOAD_BEATS = N_KEY_BEATS;
`endif
  localparam int               CNT_W     = $clog2(N_LOAD_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_LOAD_BEATS - 1);
  // Idle count that, with one more empty cycle, reaches TIMEOUT.
  localparam logic [7:0]       TO_LAST   = 8'(TIMEOUT - 1);

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
  logic [7:0]         to_cnt_q,    to_cnt_d;
  logic [KEY_W-1:0]   shadow_q,    shadow_d;
  logic [KEY_W-1:0]   key_out_q,   key_out_d;
  logic               key_valid_q, key_valid_d;
  logic               kin_ready_q, kin_ready_d;
  logic               busy_q,      busy_d;
  logic               err_q,       err_d;
  logic               beat_acc_s;

`ifdef KEY_CRC_CHECK_EN
  logic [BEAT_W-1:0]  crc_rx_q,    crc_rx_d;
  logic               chk_done_q,  chk_done_d;
  logic               chk_ok_q,    chk_ok_d;
  logic               crc_clr_s;
  logic               crc_en_s;
  logic [7:0]         crc_s;

  key_crc8 u_crc (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (crc_clr_s),
    .en_i   (crc_en_s),
    .data_i (kin_data),
    .crc_o  (crc_s)
  );
`endif

  // kin_ready is only ever high in LOAD, so this also qualifies the state.
  assign beat_acc_s = kin_valid & kin_ready_q;

  // Sequencer next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    to_cnt_d    = to_cnt_q;
    shadow_d    = shadow_q;
    key_out_d   = key_out_q;
    key_valid_d = key_valid_q;
    kin_ready_d = kin_ready_q;
    busy_d      = busy_q;
    err_d       = err_q;
`ifdef KEY_CRC_CHECK_EN
    crc_rx_d    = crc_rx_q;
    chk_done_d  = chk_done_q;
    chk_ok_d    = chk_ok_q;
    crc_clr_s   = 1'b0;
    crc_en_s    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (load_req) begin
          // Old key is pulled off the pins on the same edge the load starts.
          state_d     = LOAD;
          key_out_d   = {KEY_W{1'b0}};
          key_valid_d = 1'b0;
          err_d       = 1'b0;
          beat_cnt_d  = {CNT_W{1'b0}};
          to_cnt_d    = 8'd0;
          shadow_d    = {KEY_W{1'b0}};
          kin_ready_d = 1'b1;
          busy_d      = 1'b1;
`ifdef KEY_CRC_CHECK_EN
          crc_rx_d    = {BEAT_W{1'b0}};
          chk_done_d  = 1'b0;
          chk_ok_d    = 1'b0;
          crc_clr_s   = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (beat_acc_s) begin
          // A beat on the timeout cycle still counts and restarts the timer.
          for (int b = 0; b < N_KEY_BEATS; b++) begin
            if (beat_cnt_q == CNT_W'(b)) begin
              shadow_d[b*BEAT_W +: BEAT_W] = kin_data;
            end else begin
              shadow_d[b*BEAT_W +: BEAT_W] = shadow_q[b*BEAT_W +: BEAT_W];
            end
          end
`ifdef KEY_CRC_CHECK_EN
          if (beat_cnt_q == CNT_W'(N_KEY_BEATS)) begin
            crc_rx_d = kin_data;
          end else begin
            crc_en_s = 1'b1;
          end
`endif
          beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          to_cnt_d   = 8'd0;
          if (beat_cnt_q == LAST_BEAT) begin
            kin_ready_d = 1'b0;
            state_d     = CHECK;
          end else begin
            state_d = LOAD;
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d    = to_cnt_q + 8'd1;
          kin_ready_d = 1'b0;
          state_d     = FAIL;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
          state_d  = LOAD;
        end
      end
      CHECK: begin
`ifdef KEY_CRC_CHECK_EN
        // First cycle registers the comparison, second cycle acts on it.
        if (!chk_done_q) begin
          chk_done_d = 1'b1;
          chk_ok_d   = (crc_s == crc_rx_q);
          state_d    = CHECK;
        end else begin
          chk_done_d = 1'b0;
          state_d    = chk_ok_q ? COMMIT : FAIL;
        end
`else
        state_d = COMMIT;
`endif
      end
      COMMIT: begin
        key_out_d   = shadow_q;
        key_valid_d = 1'b1;
        busy_d      = 1'b0;
        shadow_d    = {KEY_W{1'b0}};
        state_d     = IDLE;
      end
      FAIL: begin
        err_d       = 1'b1;
        key_out_d   = {KEY_W{1'b0}};
        key_valid_d = 1'b0;
        shadow_d    = {KEY_W{1'b0}};
        kin_ready_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d     = IDLE;
        kin_ready_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset clears the key pins immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= {CNT_W{1'b0}};
      to_cnt_q    <= 8'd0;
      shadow_q    <= {KEY_W{1'b0}};
      key_out_q   <= {KEY_W{1'b0}};
      key_valid_q <= 1'b0;
      kin_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef KEY_CRC_CHECK_EN
      crc_rx_q    <= {BEAT_W{1'b0}};
      chk_done_q  <= 1'b0;
      chk_ok_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      to_cnt_q    <= to_cnt_d;
      shadow_q    <= shadow_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      kin_ready_q <= kin_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef KEY_CRC_CHECK_EN
      crc_rx_q    <= crc_rx_d;
      chk_done_q  <= chk_done_d;
      chk_ok_q    <= chk_ok_d;
`endif
    end
  end

  assign kin_ready = kin_ready_q;
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign core_out  = core_out_in & {N_OUT{key_valid_q}};

endmodule

// File: tb/tb_c432_key_load_ctrl.sv
// Self-checking bench for c432_key_load_ctrl: a transaction-level model
// (beat queue plus countdowns) predicts every registered output each cycle,
// and directed steps pin key values, latencies and timeout boundaries.
`timescale 1ns/1ps
module tb_c432_key_load_ctrl;

  localparam int TIMEOUT = 255;
`ifdef KEY_CRC_CHECK_EN
  localparam int NB_EXP = 5;
  localparam int LAT    = 3;
`else
  localparam int NB_EXP = 4;
  localparam int LAT    = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic        kin_valid = 1'b0;
  logic        kin_ready;
  logic [7:0]  kin_data = 8'h00;
  logic [31:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic [6:0]  core_out_in = 7'h7F;
  logic [6:0]  core_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  c432_key_load_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .load_req    (load_req),
    .kin_valid   (kin_valid),
    .kin_ready   (kin_ready),
    .kin_data    (kin_data),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .busy        (busy),
    .err         (err),
    .core_out_in (core_out_in),
    .core_out    (core_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bitwise CRC-8, poly 0x07, init 0x00, over a byte sequence.
  function automatic logic [7:0] ref_crc(input logic [7:0] b [$]);
    logic [7:0] c = 8'h00;
    logic       fb;
    foreach (b[k]) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[7] ^ b[k][i];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_key   = 32'd0;
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_ready = 1'b0;
  logic [7:0]  mq[$];
  int          idle_run = 0;
  int          cd = 0;
  bit          cd_fail = 1'b0;

  function automatic bit load_is_bad(input logic [7:0] b [$]);
`ifdef KEY_CRC_CHECK_EN
    logic [7:0] kb[$];
    for (int i = 0; i < 4; i++) kb.push_back(b[i]);
    return ref_crc(kb) != b[4];
`else
    return (b.size() != 4);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_key = 32'd0; m_valid = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_ready = 1'b0;
      mq.delete(); idle_run = 0; cd = 0; cd_fail = 1'b0;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        if (cd_fail) begin
          m_err = 1'b1;
        end else begin
          m_key = 32'd0;
          for (int i = 0; i < 4; i++) m_key = m_key | (32'(mq[i]) << (8 * i));
          m_valid = 1'b1;
        end
        m_busy = 1'b0;
        mq.delete();
      end
    end else if (m_ready) begin
      if (kin_valid) begin
        mq.push_back(kin_data);
        idle_run = 0;
        if (mq.size() == NB_EXP) begin
          m_ready = 1'b0; cd = LAT; cd_fail = load_is_bad(mq);
        end
      end else begin
        idle_run++;
        if (idle_run == TIMEOUT) begin
          m_ready = 1'b0; cd = 1; cd_fail = 1'b1;
        end
      end
    end else if (!m_busy && load_req) begin
      m_key = 32'd0; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b1; m_ready = 1'b1;
      idle_run = 0; mq.delete();
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      chk("m_key_out",   key_out,           m_key);
      chk("m_key_valid", 32'(key_valid),    32'(m_valid));
      chk("m_busy",      32'(busy),         32'(m_busy));
      chk("m_err",       32'(err),          32'(m_err));
      chk("m_kin_ready", 32'(kin_ready),    32'(m_ready));
      chk("m_core_out",  32'(core_out),     32'(core_out_in & {7{m_valid}}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    kin_valid = 1'b1;
    kin_data  = b;
    while (!kin_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("beat_ready_wait", 32'(kin_ready), 32'd1);
    @(negedge clk);
    kin_valid = 1'b0;
    kin_data  = 8'hA5;
  endtask

  task automatic send_key(input logic [31:0] k, input bit corrupt);
    logic [7:0] kb[$];
    for (int i = 0; i < 4; i++) begin
      kb.push_back(k[8*i +: 8]);
      send_byte(k[8*i +: 8]);
    end
`ifdef KEY_CRC_CHECK_EN
    send_byte(ref_crc(kb) ^ {7'd0, corrupt});
`else
    if (corrupt) kb.delete();
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_core_out",  32'(core_out),  32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key_out",   key_out,        32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_kin_ready", 32'(kin_ready), 32'd0);

    // Beats offered while idle must be ignored.
    kin_valid = 1'b1; kin_data = 8'hFF;
    repeat (3) @(negedge clk);
    kin_valid = 1'b0;
    chk("idle_no_ready", 32'(kin_ready), 32'd0);

    // Basic load DEADBEEF.
    pulse_load();
    chk("ready_latency", 32'(kin_ready), 32'd1);
    send_key(32'hDEADBEEF, 1'b0);
    chk("kv_after_last", 32'(key_valid), 32'd0);
    chk("ready_dropped", 32'(kin_ready), 32'd0);
    repeat (LAT - 1) @(negedge clk);
    chk("kv_one_early",  32'(key_valid), 32'd0);
    @(negedge clk);
    chk("kv_latency",    32'(key_valid), 32'd1);
    chk("key_deadbeef",  key_out,        32'hDEADBEEF);
    chk("core_ungated",  32'(core_out),  32'h7F);
    chk("busy_done",     32'(busy),      32'd0);
    core_out_in = 7'h2A;
    @(negedge clk);
    chk("core_pattern",  32'(core_out),  32'h2A);

    // Reload while valid, then let it time out.
    pulse_load();
    chk("reload_kv",     32'(key_valid), 32'd0);
    chk("reload_key",    key_out,        32'd0);
    chk("reload_busy",   32'(busy),      32'd1);
    chk("reload_gate",   32'(core_out),  32'd0);
    repeat (TIMEOUT) @(negedge clk);
    chk("to_err_not_yet", 32'(err),      32'd0);
    chk("to_ready_low",  32'(kin_ready), 32'd0);
    @(negedge clk);
    chk("to_err",        32'(err),       32'd1);
    chk("to_busy",       32'(busy),      32'd0);
    chk("to_kv",         32'(key_valid), 32'd0);
    chk("to_key",        key_out,        32'd0);

    // Async reset after two beats.
    pulse_load();
    chk("err_cleared",   32'(err),       32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",     32'(busy),      32'd0);
    chk("arst_ready",    32'(kin_ready), 32'd0);
    chk("arst_key",      key_out,        32'd0);
    chk("arst_kv",       32'(key_valid), 32'd0);
    chk("arst_core",     32'(core_out),  32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    pulse_load();
    send_key(32'h04030201, 1'b0);
    repeat (LAT) @(negedge clk);
    chk("fresh_key",     key_out,        32'h04030201);
    chk("fresh_kv",      32'(key_valid), 32'd1);

    // Beat on the timeout cycle wins; load_req during LOAD is ignored.
    pulse_load();
    chk("reload2_key",   key_out,        32'd0);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("edge_busy",     32'(busy),      32'd1);
    send_byte(8'h01);
    chk("edge_no_err",   32'(err),       32'd0);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
`ifdef KEY_CRC_CHECK_EN
    begin
      logic [7:0] kb[$];
      kb.push_back(8'h01); kb.push_back(8'h02); kb.push_back(8'h03); kb.push_back(8'h04);
      send_byte(ref_crc(kb));
    end
`endif
    repeat (LAT) @(negedge clk);
    chk("ignore_req_key", key_out,       32'h04030201);
    chk("ignore_req_kv", 32'(key_valid), 32'd1);
    chk("ignore_req_err", 32'(err),      32'd0);

`ifdef KEY_CRC_CHECK_EN
    pulse_load();
    send_key(32'hDEADBEEF, 1'b0);
    repeat (LAT) @(negedge clk);
    chk("crc_ok_key",    key_out,        32'hDEADBEEF);
    chk("crc_ok_kv",     32'(key_valid), 32'd1);
    pulse_load();
    send_key(32'hDEADBEEF, 1'b1);
    repeat (LAT) @(negedge clk);
    chk("crc_bad_err",   32'(err),       32'd1);
    chk("crc_bad_key",   key_out,        32'd0);
    chk("crc_bad_kv",    32'(key_valid), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
